lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller for a 256x32 synchronous data memory.
//
// Accepts one RISC-V load/store request at a time, checks width code and
// alignment, performs the memory access and returns a single-cycle response.
// Sub-word stores are done as read-modify-write of the containing word.
//
// Sequences (cycle 0 = accept cycle):
//   illegal : IDLE -> RESP                 (resp in cycle 1)
//   SW      : IDLE -> WR -> RESP           (resp in cycle 2)
//   load    : IDLE -> RD -> RDW -> RESP    (resp in cycle 3)
//   SB/SH   : IDLE -> RD -> RDW -> WR -> RESP (resp in cycle 4)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   req_valid      in   request present (held by requester until accepted)
//   req_ready      out  high only in IDLE
//   req_we         in   1 = store, 0 = load
//   req_funct3     in   width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   req_addr       in   byte address (bits [31:10] ignored, 1 KiB wrap)
//   req_wdata      in   store data, lane 0 aligned
//   resp_valid     out  one-cycle completion pulse
//   resp_rdata     out  extended load data, 0 for stores/errors/idle
//   resp_err       out  misaligned or illegal width code
//   mem_read_flag  out  read strobe, high for the RD cycle only
//   mem_write_flag out  write strobe, high for the WR cycle only
//   mem_addr       out  word address
//   mem_wdata      out  word to write
//   mem_rdata      in   word returned by memory (valid during RDW)
// ---------------------------------------------------------------------------
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read_flag,
    output logic        mem_write_flag,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    // Legal width code for the direction, plus natural alignment.
    function automatic logic access_legal(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = (off[0] == 1'b0);
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h00_0000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the sampled word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (f3)
            F3_B:    r[{off, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_read_flag_q, mem_read_flag_d;
    logic        mem_write_flag_q, mem_write_flag_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        legal_s;

    // Upper address bits select nothing: the memory is only 1 KiB.
    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[31:10];

    // Next-state, strobe and response computation.
    always_comb begin
        state_d          = state_q;
        req_ready_d      = 1'b0;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = 32'h0000_0000;
        resp_err_d       = 1'b0;
        mem_read_flag_d  = 1'b0;
        mem_write_flag_d = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        we_d             = we_q;
        funct3_d         = funct3_q;
        off_d            = off_q;
        wdata_d          = wdata_q;
        legal_s          = access_legal(req_we, req_funct3, req_addr[1:0]);

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d       = req_we;
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[9:2];
                    if (!legal_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d         = S_RD;
                        mem_read_flag_d = 1'b1;
                    end else if (req_funct3 == F3_W) begin
                        // Full-word store needs no read of the old word.
                        state_d          = S_WR;
                        mem_write_flag_d = 1'b1;
                        mem_wdata_d      = req_wdata;
                    end else begin
                        state_d         = S_RD;
                        mem_read_flag_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_RD: begin
                state_d = S_RDW;
            end
            S_RDW: begin
                // mem_rdata is valid now; sample it on leaving RDW.
                if (we_q) begin
                    state_d          = S_WR;
                    mem_write_flag_d = 1'b1;
                    mem_wdata_d      = store_merge(mem_rdata, wdata_q, funct3_q, off_q);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(mem_rdata, funct3_q, off_q);
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0000_0000;
            resp_err_q       <= 1'b0;
            mem_read_flag_q  <= 1'b0;
            mem_write_flag_q <= 1'b0;
            mem_addr_q       <= 8'h00;
            mem_wdata_q      <= 32'h0000_0000;
            we_q             <= 1'b0;
            funct3_q         <= 3'd0;
            off_q            <= 2'd0;
            wdata_q          <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mem_read_flag_q  <= mem_read_flag_d;
            mem_write_flag_q <= mem_write_flag_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            we_q             <= we_d;
            funct3_q         <= funct3_d;
            off_q            <= off_d;
            wdata_q          <= wdata_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_read_flag  = mem_read_flag_q;
    assign mem_write_flag = mem_write_flag_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl with a 256x32 memory model.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [7:0]  maddr;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          viol = 0;
    int          idle_viol = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_total = 0;
    int          resp_total = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  last_addr = 8'h00;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [31:0] pl_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory model: synchronous read, write on strobe, plus bench preload.
    initial begin
        forever begin
            @(posedge clk);
            if (pl_en) mem[pl_addr] <= pl_data;
            if (mem_write_flag) mem[mem_addr] <= mem_wdata;
            if (mem_read_flag) mem_rdata <= mem[mem_addr];
        end
    end

    // Accept recorder and cycle counter.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && req_valid && req_ready) acc_q.push_back(cyc);
            cyc = cyc + 1;
        end
    end

    // Monitor: strobe rules, idle-zero rule and scoreboard comparison.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt = 0;
                wr_cnt = 0;
                prev_strobe = 1'b0;
                acc_q.delete();
            end else begin
                if (mem_read_flag && mem_write_flag) viol++;
                if ((mem_read_flag || mem_write_flag) && prev_strobe) viol++;
                prev_strobe = mem_read_flag || mem_write_flag;
                if (mem_read_flag) begin rd_cnt++; last_addr = mem_addr; end
                if (mem_write_flag) begin wr_cnt++; wr_total++; last_addr = mem_addr; end
                if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) idle_viol++;
                if (resp_valid) begin
                    resp_total++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp actual=resp_valid required=none");
                    end else begin
                        e = exp_q.pop_front();
                        a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("latency", cyc - a, e.lat);
                        chk("read_pulses", rd_cnt, e.nrd);
                        chk("write_pulses", wr_cnt, e.nwr);
                        if (e.nrd + e.nwr > 0) chk("mem_addr", {24'd0, last_addr}, {24'd0, e.maddr});
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one request; starts and ends at a negedge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hold, input logic push,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int nrd, input int nwr, input logic [7:0] maddr);
        exp_t e;
        int   n;
        e.err = err; e.rdata = rdata; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.maddr = maddr;
        if (push) exp_q.push_back(e);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready addr=%h", addr);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int wr_before;
        int resp_before;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_strobes", {30'd0, mem_read_flag, mem_write_flag}, 32'd0);
        chk("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        poke(8'd5, 32'h8899AABB);
        poke(8'd2, 32'h11223344);
        poke(8'd4, 32'hA5A5A5A5);
        @(negedge clk);

        // Loads: we f3 addr wdata hold push err rdata lat nrd nwr maddr
        issue(1'b0, 3'd0, 32'h16, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFFFF99, 3, 1, 0, 8'd5);
        issue(1'b0, 3'd5, 32'h14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000AABB, 3, 1, 0, 8'd5);
        issue(1'b0, 3'd1, 32'h16, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF8899, 3, 1, 0, 8'd5);
        issue(1'b0, 3'd4, 32'h17, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00000088, 3, 1, 0, 8'd5);
        issue(1'b0, 3'd2, 32'hFFFFFC14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8899AABB, 3, 1, 0, 8'd5);
        drain();

        // Stores
        issue(1'b1, 3'd0, 32'h09, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 4, 1, 1, 8'd2);
        drain();
        chk("sb_merge", mem[2], 32'h1122EF44);
        issue(1'b1, 3'd2, 32'h40C, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0, 2, 0, 1, 8'd3);
        drain();
        chk("sw_wrap", mem[3], 32'hCAFEF00D);
        issue(1'b1, 3'd1, 32'h0A, 32'h00005566, 1'b0, 1'b1, 1'b0, 32'h0, 4, 1, 1, 8'd2);
        drain();
        chk("sh_merge", mem[2], 32'h5566EF44);

        // Illegal accesses
        issue(1'b0, 3'd2, 32'h02, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0, 0, 8'd0);
        issue(1'b0, 3'd3, 32'h00, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0, 0, 8'd0);
        issue(1'b1, 3'd1, 32'h21, 32'h1234, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0, 0, 8'd0);
        issue(1'b1, 3'd4, 32'h20, 32'h1234, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0, 0, 8'd0);
        issue(1'b0, 3'd5, 32'h15, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0, 0, 8'd0);
        drain();

        // Reset during RDW of an SB: no write, no response.
        wr_before = wr_total;
        resp_before = resp_total;
        issue(1'b1, 3'd0, 32'h10, 32'h00000012, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_write", wr_total, wr_before);
        chk("abort_no_resp", resp_total, resp_before);
        chk("abort_mem", mem[4], 32'hA5A5A5A5);

        // Back-to-back LW with req_valid held high.
        resp_before = resp_total;
        issue(1'b0, 3'd2, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8899AABB, 3, 1, 0, 8'd5);
        issue(1'b0, 3'd2, 32'h08, 32'h0, 1'b1, 1'b1, 1'b0, 32'h5566EF44, 3, 1, 0, 8'd2);
        issue(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 3, 1, 0, 8'd3);
        drain();
        chk("b2b_resp_count", resp_total - resp_before, 32'd3);

        chk("strobe_rules", viol, 32'd0);
        chk("idle_resp_zero", idle_viol, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
